// File: rtl/pool_pkg.sv
// Shared pooling definitions: mode encodings, default widths and the signed-max helper.
package pool_pkg;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_AVG = 1'b1;

    // Default sample width and the widths of the pair sum and the window sum
    localparam int unsigned POOL_DATA_W = 8;
    localparam int unsigned POOL_PAIR_W = POOL_DATA_W + 1;
    localparam int unsigned POOL_WIN_W  = POOL_DATA_W + 2;

    // Width of the generic signed-max operands; callers sign-extend into it
    localparam int unsigned SMAX_W = 32;

    // Two's complement max: opposite signs pick the non-negative one,
    // equal signs compare the remaining magnitude bits
    function automatic logic [SMAX_W-1:0] signed_max(input logic [SMAX_W-1:0] a,
                                                     input logic [SMAX_W-1:0] b);
        logic [SMAX_W-1:0] r;
        if (a[SMAX_W-1] != b[SMAX_W-1]) begin
            r = a[SMAX_W-1] ? b : a;
        end else begin
            r = (a[SMAX_W-2:0] > b[SMAX_W-2:0]) ? a : b;
        end
        return r;
    endfunction

endpackage

// File: rtl/pool_combine.sv
// One-channel combine stage: signed max (sign-extended) or full-width signed sum.
module pool_combine
    import pool_pkg::*;
#(
    parameter int unsigned W = POOL_DATA_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         mode,
    output logic [W:0]   y
);

    logic [SMAX_W-1:0] max_c;

    // Max path widens both operands so the shared helper can be reused at any width
    always_comb begin
        max_c = signed_max(SMAX_W'($signed(a)), SMAX_W'($signed(b)));
        if (mode == MODE_AVG) begin
            y = (W+1)'($signed(a)) + (W+1)'($signed(b));
        end else begin
            y = (W+1)'(max_c);
        end
    end

endmodule

// File: rtl/max_pool_stream.sv
// Streaming 2x2 / stride-2 max or average pooling over a raster-order feature map.
module max_pool_stream
    import pool_pkg::*;
#(
    parameter int unsigned DATA_W = POOL_DATA_W,
    parameter int unsigned CH     = 1,
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [CH*DATA_W-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [CH*DATA_W-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last
);

    localparam int unsigned PAIR_W   = DATA_W + 1;
    localparam int unsigned WIN_W    = DATA_W + 2;
    localparam int unsigned BUS_W    = CH * DATA_W;
    localparam int unsigned COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned LB_DEPTH = IMG_W / 2;
    localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic                mode_q, mode_d;
    logic [BUS_W-1:0]    pair_q, pair_d;
    logic                out_valid_q, out_valid_d;
    logic [BUS_W-1:0]    out_data_q, out_data_d;
    logic                out_last_q, out_last_d;

    logic                accept_c;
    logic                col_last_c;
    logic                row_last_c;
    logic [LB_AW-1:0]    lb_idx_c;
    logic [CH*PAIR_W-1:0] lb_rd_c;
    logic [CH*PAIR_W-1:0] h_c;
    logic [CH*WIN_W-1:0]  v_c;
    logic [BUS_W-1:0]    res_c;

    logic [CH*PAIR_W-1:0] lb_mem [LB_DEPTH];

    // Upstream may push whenever the output slot is free or being drained this cycle
    assign in_ready   = !out_valid_q || out_ready;
    assign accept_c   = in_valid && in_ready;
    assign col_last_c = (col_q == COL_W'(IMG_W - 1));
    assign row_last_c = (row_q == ROW_W'(IMG_H - 1));
    assign lb_idx_c   = LB_AW'(col_q >> 1);
    assign lb_rd_c    = lb_mem[lb_idx_c];

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

    // Per-channel horizontal (pair) and vertical (line) combine, then final scaling
    for (genvar ch = 0; ch < CH; ch++) begin : g_ch
        pool_combine #(.W(DATA_W)) u_h (
            .a    (pair_q[ch*DATA_W +: DATA_W]),
            .b    (in_data[ch*DATA_W +: DATA_W]),
            .mode (mode_q),
            .y    (h_c[ch*PAIR_W +: PAIR_W])
        );

        pool_combine #(.W(PAIR_W)) u_v (
            .a    (lb_rd_c[ch*PAIR_W +: PAIR_W]),
            .b    (h_c[ch*PAIR_W +: PAIR_W]),
            .mode (mode_q),
            .y    (v_c[ch*WIN_W +: WIN_W])
        );

        // Avg divides the 4-sample sum by 4 (arithmetic shift); max already fits DATA_W
        assign res_c[ch*DATA_W +: DATA_W] = (mode_q == MODE_AVG)
                                          ? v_c[ch*WIN_W + 2 +: DATA_W]
                                          : v_c[ch*WIN_W +: DATA_W];
    end

    // Next-state: raster counters, pair hold, mode latch and output slot
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        mode_d      = mode_q;
        pair_d      = pair_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept_c) begin
            if ((col_q == '0) && (row_q == '0)) begin
                mode_d = mode;
            end

            if (!col_q[0]) begin
                pair_d = in_data;
            end

            if (col_last_c) begin
                col_d = '0;
                row_d = row_last_c ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end

            if (col_q[0] && row_q[0]) begin
                out_valid_d = 1'b1;
                out_data_d  = res_c;
                out_last_d  = row_last_c && col_last_c;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= MODE_MAX;
            pair_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            mode_q      <= mode_d;
            pair_q      <= pair_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Line buffer: even rows deposit pair results, odd rows read them back; never reset
    always_ff @(posedge clk) begin
        if (accept_c && col_q[0] && !row_q[0]) begin
            lb_mem[lb_idx_c] <= h_c;
        end
    end

endmodule

// File: tb/tb_max_pool_stream.sv
// Bench for max_pool_stream: directed 4x2 table frames and random 28x28 CH=3 streams.
module tb_max_pool_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Small instance: 4x2 frame, one channel
    logic       s_rst, s_mode, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last;
    logic [7:0] s_in_data, s_out_data;

    // Large instance: 28x28 frame, three channels
    logic        l_rst, l_mode, l_in_valid, l_in_ready, l_out_valid, l_out_ready, l_out_last;
    logic [23:0] l_in_data, l_out_data;

    max_pool_stream #(.DATA_W(8), .CH(1), .IMG_W(4), .IMG_H(2)) dut_s (
        .clk       (clk),
        .rst       (s_rst),
        .mode      (s_mode),
        .in_data   (s_in_data),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .out_data  (s_out_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_last  (s_out_last)
    );

    max_pool_stream #(.DATA_W(8), .CH(3), .IMG_W(28), .IMG_H(28)) dut_l (
        .clk       (clk),
        .rst       (l_rst),
        .mode      (l_mode),
        .in_data   (l_in_data),
        .in_valid  (l_in_valid),
        .in_ready  (l_in_ready),
        .out_data  (l_out_data),
        .out_valid (l_out_valid),
        .out_ready (l_out_ready),
        .out_last  (l_out_last)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- small instance helpers ----------------
    logic [7:0] s_got_d[$];
    logic       s_got_l[$];

    always @(negedge clk) begin
        if (s_out_valid && s_out_ready) begin
            s_got_d.push_back(s_out_data);
            s_got_l.push_back(s_out_last);
        end
    end

    task automatic send_s(input logic [7:0] d);
        int  guard = 0;
        bit  done  = 0;
        while (!done) begin
            @(posedge clk); #1;
            s_in_valid = 1'b1;
            s_in_data  = d;
            @(negedge clk);
            if (s_in_ready) begin
                done = 1;
            end else begin
                guard++;
                if (guard > 200) begin
                    check("s_in_timeout", 32'd1, 32'd0);
                    done = 1;
                end
            end
        end
    endtask

    task automatic idle_s();
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        s_in_data  = 8'($urandom);
    endtask

    typedef struct packed {
        logic            mode;
        logic [7:0][7:0] px;
        logic [7:0]      e0;
        logic [7:0]      e1;
    } vec_t;

    function automatic vec_t mk(input logic md, input int p0, input int p1, input int p2,
                                input int p3, input int p4, input int p5, input int p6,
                                input int p7, input int e0, input int e1);
        vec_t v;
        v.mode  = md;
        v.px[0] = 8'(p0); v.px[1] = 8'(p1); v.px[2] = 8'(p2); v.px[3] = 8'(p3);
        v.px[4] = 8'(p4); v.px[5] = 8'(p5); v.px[6] = 8'(p6); v.px[7] = 8'(p7);
        v.e0    = 8'(e0);
        v.e1    = 8'(e1);
        return v;
    endfunction

    task automatic run_frame_s(input vec_t v, input string tag);
        s_got_d.delete();
        s_got_l.delete();
        s_mode = v.mode;
        for (int i = 0; i < 8; i++) send_s(v.px[i]);
        idle_s();
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_count"}, 32'(s_got_d.size()), 32'd2);
        if (s_got_d.size() >= 2) begin
            check({tag, "_w0"},    32'(s_got_d[0]), 32'(v.e0));
            check({tag, "_w1"},    32'(s_got_d[1]), 32'(v.e1));
            check({tag, "_last0"}, 32'(s_got_l[0]), 32'd0);
            check({tag, "_last1"}, 32'(s_got_l[1]), 32'd1);
        end
    endtask

    // ---------------- large instance helpers and model ----------------
    logic [23:0] fpx [784];
    logic [23:0] exp_d[$];
    logic        exp_l[$];
    int          l_out_cnt = 0;
    bit          l_rand_rdy = 0;

    function automatic int pxv(input int idx, input int ch);
        logic signed [7:0] t;
        t = fpx[idx][ch*8 +: 8];
        return int'(t);
    endfunction

    // Window result straight from the definition: max of four, or floor(sum/4)
    function automatic logic [23:0] ref_window(input logic md, input int wr, input int wc);
        logic [23:0] r;
        int idx;
        r   = '0;
        idx = (2 * wr) * 28 + 2 * wc;
        for (int ch = 0; ch < 3; ch++) begin
            int v[4];
            int acc;
            v[0] = pxv(idx, ch);
            v[1] = pxv(idx + 1, ch);
            v[2] = pxv(idx + 28, ch);
            v[3] = pxv(idx + 29, ch);
            if (!md) begin
                acc = v[0];
                for (int k = 1; k < 4; k++) if (v[k] > acc) acc = v[k];
            end else begin
                acc = v[0] + v[1] + v[2] + v[3];
                acc = (acc >= 0) ? acc / 4 : -((-acc + 3) / 4);
            end
            r[ch*8 +: 8] = 8'(acc);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (l_out_valid && l_out_ready) begin
            l_out_cnt++;
            if (exp_d.size() == 0) begin
                check("l_unexpected_out", 32'd1, 32'd0);
            end else begin
                check("l_data", 32'(l_out_data), 32'(exp_d[0]));
                check("l_last", 32'(l_out_last), 32'(exp_l[0]));
                void'(exp_d.pop_front());
                void'(exp_l.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (l_rand_rdy) l_out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic send_l(input logic [23:0] d);
        int guard = 0;
        bit done  = 0;
        while (!done) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 3) == 0) begin
                l_in_valid = 1'b0;
                l_in_data  = 24'($urandom);
            end else begin
                l_in_valid = 1'b1;
                l_in_data  = d;
            end
            @(negedge clk);
            if (l_in_valid && l_in_ready) begin
                done = 1;
            end else begin
                guard++;
                if (guard > 1000) begin
                    check("l_in_timeout", 32'd1, 32'd0);
                    done = 1;
                end
            end
        end
    endtask

    // ---------------- main sequence ----------------
    vec_t vt[6];
    vec_t bp;
    vec_t clean;

    initial begin
        s_rst = 1'b1; s_mode = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
        l_rst = 1'b1; l_mode = 1'b0; l_in_valid = 1'b0; l_in_data = '0; l_out_ready = 1'b1;

        vt[0] = mk(1'b0,    1,    5,   -3,    2,    4,   -8,    7,    0,    5,    7);
        vt[1] = mk(1'b0, -128,   -1,   -1,    0,   -2, -128,  127, -128,   -1,  127);
        vt[2] = mk(1'b1,    3,    4,   -1,   -1,    5,    6,   -1,   -2,    4,   -2);
        vt[3] = mk(1'b1,  127,  127, -128, -128,  127,  127, -128, -128,  127, -128);
        vt[4] = mk(1'b1,    1,    2,   -3,    0,    0,    0,    1,    0,    0,   -1);
        vt[5] = mk(1'b0,   -5,   -6,   -7,   -8,   -9,  -10, -128,   -3,   -5,   -3);

        repeat (3) @(posedge clk);
        #1;
        s_rst = 1'b0;
        l_rst = 1'b0;
        @(negedge clk);
        check("s_rst_valid", 32'(s_out_valid), 32'd0);
        check("s_rst_last",  32'(s_out_last),  32'd0);
        check("s_rst_data",  32'(s_out_data),  32'd0);
        check("s_rst_ready", 32'(s_in_ready),  32'd1);
        check("l_rst_valid", 32'(l_out_valid), 32'd0);
        check("l_rst_data",  32'(l_out_data),  32'd0);

        // Directed frames: basic max, sign corners, average rounding
        for (int i = 0; i < 6; i++) run_frame_s(vt[i], $sformatf("vec%0d", i));

        // Back-pressure: hold the first window's result for 5 cycles
        bp = mk(1'b0, 10, 20, -5, -6, 30, 1, -7, -100, 30, -5);
        s_got_d.delete();
        s_got_l.delete();
        s_mode = bp.mode;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_s(bp.px[i]);
        @(posedge clk); #1;
        s_in_valid = 1'b1;
        s_in_data  = bp.px[6];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid",    32'(s_out_valid), 32'd1);
            check("bp_in_ready", 32'(s_in_ready),  32'd0);
            check("bp_data",     32'(s_out_data),  32'(bp.e0));
            @(posedge clk); #1;
        end
        s_out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 32'(s_in_ready), 32'd1);
        send_s(bp.px[7]);
        idle_s();
        repeat (3) @(posedge clk);
        #1;
        check("bp_count", 32'(s_got_d.size()), 32'd2);
        if (s_got_d.size() >= 2) begin
            check("bp_w0",    32'(s_got_d[0]), 32'(bp.e0));
            check("bp_w1",    32'(s_got_d[1]), 32'(bp.e1));
            check("bp_last1", 32'(s_got_l[1]), 32'd1);
        end

        // Reset mid-frame with a result pending, then a clean frame
        s_mode = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_s(8'($urandom));
        idle_s();
        @(negedge clk);
        check("rst_pending", 32'(s_out_valid), 32'd1);
        @(posedge clk); #1;
        s_rst = 1'b1;
        @(posedge clk); #1;
        s_rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(s_out_valid), 32'd0);
        check("rst_last",  32'(s_out_last),  32'd0);
        check("rst_data",  32'(s_out_data),  32'd0);
        @(posedge clk); #1;
        s_out_ready = 1'b1;
        clean = vt[5];
        run_frame_s(clean, "post_rst");

        // Random 28x28 CH=3 frames back-to-back, mode flipped mid-frame
        l_rand_rdy = 1;
        for (int f = 0; f < 3; f++) begin
            logic md;
            md = (f == 1);
            for (int i = 0; i < 784; i++) fpx[i] = 24'($urandom);
            for (int wr = 0; wr < 14; wr++) begin
                for (int wc = 0; wc < 14; wc++) begin
                    exp_d.push_back(ref_window(md, wr, wc));
                    exp_l.push_back((wr == 13) && (wc == 13));
                end
            end
            l_mode = md;
            for (int i = 0; i < 784; i++) begin
                if (i == 300) l_mode = ~md;
                send_l(fpx[i]);
            end
        end
        @(posedge clk); #1;
        l_in_valid = 1'b0;
        l_rand_rdy = 0;
        l_out_ready = 1'b1;
        begin
            int w;
            w = 0;
            while (exp_d.size() != 0 && w < 5000) begin
                @(posedge clk);
                w++;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        check("l_drain",     32'(exp_d.size()), 32'd0);
        check("l_out_count", 32'(l_out_cnt),    32'd588);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
